// File: rtl/somador_pkg.sv
// rtl/somador_pkg.sv - shared FSM encoding and counter-width helper for the serial adder
package somador_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        SOMANDO = 2'd1,
        FIM     = 2'd2
    } estado_t;

    // Bit counter needs clog2(n) bits, but never fewer than one.
    function automatic int largura_contador(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/meio_somador.sv
// rtl/meio_somador.sv - one-bit half adder
module meio_somador (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/somador_completo.sv
// rtl/somador_completo.sv - one-bit full adder from two half adders and an OR of their carries
module somador_completo (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic s_parcial;
    logic c_primeiro;
    logic c_segundo;

    meio_somador u_meio_a (
        .a (a),
        .b (b),
        .s (s_parcial),
        .c (c_primeiro)
    );

    meio_somador u_meio_b (
        .a (s_parcial),
        .b (c_in),
        .s (s),
        .c (c_segundo)
    );

    assign c_out = c_primeiro | c_segundo;

endmodule

// File: rtl/controlador_somador_serial.sv
// rtl/controlador_somador_serial.sv - bit-serial N-bit adder, LSB first, one bit per clock
// Optional subtraction (A + ~B + 1) enabled by defining SOMADOR_SUBTRACAO_EN.
module controlador_somador_serial
    import somador_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inicio,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
`ifdef SOMADOR_SUBTRACAO_EN
    input  logic         sub,
`endif
    output logic [N-1:0] S,
    output logic         C_out,
    output logic         ocupado,
    output logic         pronto
);

    localparam int CW = largura_contador(N);
    localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

    estado_t       estado;
    estado_t       prox;
    logic [N-1:0]  ra;
    logic [N-1:0]  rb;
    logic [N-1:0]  rs;
    logic [N-1:0]  rs_prox;
    logic [N-1:0]  b_carga;
    logic          carry;
    logic          carry_ini;
    logic          carry_prox;
    logic          soma;
    logic [CW-1:0] cont;

`ifdef SOMADOR_SUBTRACAO_EN
    assign b_carga   = sub ? ~B : B;
    assign carry_ini = sub;
`else
    assign b_carga   = B;
    assign carry_ini = 1'b0;
`endif

    somador_completo u_somador (
        .a     (ra[0]),
        .b     (rb[0]),
        .c_in  (carry),
        .s     (soma),
        .c_out (carry_prox)
    );

    // New sum bit enters at the MSB so the result is aligned after N steps.
    always_comb begin
        rs_prox        = rs >> 1;
        rs_prox[N-1]   = soma;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox;
        end
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:  if (inicio) prox = SOMANDO;
            SOMANDO: if (cont == ULTIMO) prox = FIM;
            FIM:     prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            carry <= 1'b0;
            cont  <= '0;
            S     <= '0;
            C_out <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        ra    <= A;
                        rb    <= b_carga;
                        carry <= carry_ini;
                        cont  <= '0;
                    end
                end
                SOMANDO: begin
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    rs    <= rs_prox;
                    carry <= carry_prox;
                    cont  <= cont + CW'(1);
                    if (cont == ULTIMO) begin
                        S     <= rs_prox;
                        C_out <= carry_prox;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ocupado = (estado == SOMANDO);
    assign pronto  = (estado == FIM);

endmodule

// File: tb/tb_controlador_somador_serial.sv
// tb/tb_controlador_somador_serial.sv - directed self-checking bench for the serial adder controller
module tb_controlador_somador_serial;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sb;
        logic [7:0] s;
        logic       c;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inicio = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic [7:0] S;
    logic       C_out, ocupado, pronto;
`ifdef SOMADOR_SUBTRACAO_EN
    logic       sub = 1'b0;
    logic       sub1 = 1'b0;
`endif

    logic       inicio1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic [0:0] s1;
    logic       c1, ocupado1, pronto1;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] prev_s = '0;
    vec_t       tv[$];

    always #5 clk = ~clk;

    controlador_somador_serial #(.N(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inicio  (inicio),
        .A       (A),
        .B       (B),
`ifdef SOMADOR_SUBTRACAO_EN
        .sub     (sub),
`endif
        .S       (S),
        .C_out   (C_out),
        .ocupado (ocupado),
        .pronto  (pronto)
    );

    controlador_somador_serial #(.N(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .inicio  (inicio1),
        .A       (a1),
        .B       (b1),
`ifdef SOMADOR_SUBTRACAO_EN
        .sub     (sub1),
`endif
        .S       (s1),
        .C_out   (c1),
        .ocupado (ocupado1),
        .pronto  (pronto1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One operation on the N=8 instance; operands are scrambled right after acceptance.
    task automatic op(input vec_t v);
        int busy;
        bit seen;
        @(negedge clk);
        A      = v.a;
        B      = v.b;
`ifdef SOMADOR_SUBTRACAO_EN
        sub    = v.sb;
`endif
        inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        A      = ~v.a;
        B      = ~v.b;
`ifdef SOMADOR_SUBTRACAO_EN
        sub    = ~v.sb;
`endif
        busy = 0;
        seen = 1'b0;
        for (int j = 0; j < 40 && !seen; j++) begin
            @(negedge clk);
            if (j == 0) chk("S_held_at_start", 32'(S), 32'(prev_s));
            if (pronto) begin
                seen = 1'b1;
                chk("busy_cycles", 32'(busy), 32'd8);
                chk("sum", 32'(S), 32'(v.s));
                chk("carry", 32'(C_out), 32'(v.c));
                chk("ocupado_at_pronto", 32'(ocupado), 32'd0);
            end else if (ocupado) begin
                busy++;
            end
        end
        if (!seen) chk("pronto_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("pronto_width", 32'(pronto), 32'd0);
        prev_s = v.s;
    endtask

    initial begin
        tv.push_back('{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0});
        tv.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
        tv.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
        tv.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
        tv.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0});
        tv.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
        tv.push_back('{8'h12, 8'h34, 1'b0, 8'h46, 1'b0});
`ifdef SOMADOR_SUBTRACAO_EN
        tv.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1});
        tv.push_back('{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0});
        tv.push_back('{8'h55, 8'h55, 1'b1, 8'h00, 1'b1});
        tv.push_back('{8'h20, 8'h05, 1'b0, 8'h25, 1'b0});
`endif

        repeat (3) @(negedge clk);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_C_out", 32'(C_out), 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_pronto", 32'(pronto), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (tv[i]) op(tv[i]);

        // inicio held high: one result every 10 cycles, A disturbed mid-operation
        @(negedge clk);
        A      = 8'h01;
        B      = 8'h02;
`ifdef SOMADOR_SUBTRACAO_EN
        sub    = 1'b0;
`endif
        inicio = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            chk("cont_ocupado", 32'(ocupado), 32'((j % 10) < 8));
            chk("cont_pronto", 32'(pronto), 32'((j % 10) == 8));
            if (pronto) begin
                chk("cont_sum", 32'(S), 32'h03);
                chk("cont_carry", 32'(C_out), 32'd0);
            end
            if (j == 2) A = 8'hF0;
            if (j == 5) A = 8'h01;
        end
        inicio = 1'b0;
        repeat (12) @(negedge clk);
        prev_s = 8'h03;

        // reset in the middle of an operation
        @(negedge clk);
        A      = 8'hAA;
        B      = 8'h55;
        inicio = 1'b1;
        @(posedge clk);
        #1 inicio = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_S", 32'(S), 32'd0);
        chk("midrst_C_out", 32'(C_out), 32'd0);
        chk("midrst_ocupado", 32'(ocupado), 32'd0);
        chk("midrst_pronto", 32'(pronto), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int np;
            np = 0;
            for (int j = 0; j < 12; j++) begin
                @(negedge clk);
                if (pronto || ocupado) np++;
            end
            chk("no_pronto_after_rst", 32'(np), 32'd0);
        end
        prev_s = 8'h00;
        op('{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0});

        // N=1 instance: pronto two edges after acceptance
        @(negedge clk);
        a1      = 1'b1;
        b1      = 1'b1;
        inicio1 = 1'b1;
        @(posedge clk);
        #1 inicio1 = 1'b0;
        @(negedge clk);
        chk("n1_ocupado", 32'(ocupado1), 32'd1);
        chk("n1_pronto_early", 32'(pronto1), 32'd0);
        @(negedge clk);
        chk("n1_pronto", 32'(pronto1), 32'd1);
        chk("n1_sum", 32'(s1), 32'd0);
        chk("n1_carry", 32'(c1), 32'd1);
        chk("n1_ocupado_done", 32'(ocupado1), 32'd0);
        @(negedge clk);
        chk("n1_pronto_width", 32'(pronto1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
